// File: rtl/uart_pkg.sv
// uart_pkg: shared states, widths and the majority voter for the UART receiver.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through buffer; head reads as zero when empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign wr_d    = wr_q + AW'(wr_en);
    assign rd_d    = rd_q + AW'(rd_en);
    assign count_d = count_q + CW'(wr_en) - CW'(rd_en);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled 8N1 receiver with 3-sample majority vote,
// framing/overrun pulses and a FWFT receive buffer.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [UART_DATA_W-1:0]       rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(UART_OVERSAMPLE);
    localparam int SP  = UART_OVERSAMPLE / 2 - 1;

    uart_state_e            state_q, state_d;
    logic [1:0]             sync_q;
    logic                   prev_q, prev_d;
    logic [DW-1:0]          div_q, div_d;
    logic [SW-1:0]          s_q, s_d;
    logic [2:0]             samp_q, samp_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [2:0]             idx_q, idx_d;
    logic                   ferr_q, ferr_d, ovr_q, ovr_d;
    logic                   rx_s, active, tick, last, bit_v, push, full, empty;

    assign rx_s      = sync_q[1];
    assign active    = state_q inside {START, DATA, STOP};
    assign tick      = active && div_q == DW'(DIV - 1);
    assign last      = tick && s_q == SW'(UART_OVERSAMPLE - 1);
    assign bit_v     = maj3(samp_q[2], samp_q[1], samp_q[0]);
    assign ovr_d     = push && full && !rx_ready;
    assign rx_valid  = !empty;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            div_q   <= '0;
            s_q     <= '0;
            samp_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            prev_q  <= prev_d;
            div_q   <= div_d;
            s_q     <= s_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        // prev is held high outside IDLE so a start bit already low on the first IDLE cycle still counts
        prev_d  = (state_q == IDLE) ? rx_s : 1'b1;
        div_d   = (!active || tick) ? '0 : div_q + DW'(1);
        s_d     = !active ? '0 : s_q + SW'(tick);
        samp_d  = (tick && s_q >= SW'(SP) && s_q <= SW'(SP + 2)) ? {samp_q[1:0], rx_s} : samp_q;
        case (state_q)
            IDLE:  if (prev_q && !rx_s) state_d = START;
            START: if (last) begin
                state_d = bit_v ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA:  if (last) begin
                data_d  = {bit_v, data_q[UART_DATA_W-1:1]};
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP:  if (last) begin
                push    = bit_v;
                ferr_d  = !bit_v;
                state_d = bit_v ? IDLE : BREAK;
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (data_q),
        .pop_i   (rx_ready),
        .dout_o  (rx_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: scoreboard bench for the UART receiver at 32 clocks per bit.
module tb_uart_rx_oversampled;
    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [2:0] fifo_count;

    int         n_cmp = 0, n_bad = 0;
    int         ferr_cnt = 0, ovr_cnt = 0, vld_cnt = 0;
    int         got_rd = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
    );

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid) vld_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        step(32);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(32);
        end
        rx = stop_v;
        step(32);
    endtask

    task automatic wait_got(input int n);
        for (int c = 0; c < 2000 && (got_q.size() - got_rd) < n; c++) step(1);
        step(4);
    endtask

    task automatic test_reset();
        step(2);
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b data=%02h count=%0d ferr=%b ovr=%b, need 0 00 0 0 0", rx_valid, rx_data, fifo_count, frame_err, overrun);
        end
        rst = 1'b0;
        step(8);
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_outputs: valid=%b data=%02h count=%0d, need 0 00 0", rx_valid, rx_data, fifo_count);
        end
    endtask

    task automatic test_single();
        int f0 = ferr_cnt, o0 = ovr_cnt, v0 = vld_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_got(exp_q.size());
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL single_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL single_data: got %02h, need %02h", g, e); end
        end
        n_cmp++;
        if (vld_cnt - v0 != 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d, need 1", vld_cnt - v0); end
        n_cmp++;
        if (ferr_cnt != f0 || ovr_cnt != o0) begin
            n_bad++;
            $display("FAIL single_pulses: ferr %0d ovr %0d, need 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_framing();
        int f0 = ferr_cnt, o0 = ovr_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        step(96);
        rx = 1'b1;
        step(40);
        n_cmp++;
        if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL framing_pulse: got %0d pulse cycles, need 1", ferr_cnt - f0); end
        n_cmp++;
        if (got_q.size() != got_rd || fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL framing_nopush: got %0d bytes count=%0d, need 0 0", got_q.size() - got_rd, fifo_count);
        end
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_got(exp_q.size());
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL framing_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL framing_next: got %02h, need %02h", g, e); end
        end
        n_cmp++;
        if (ferr_cnt - f0 != 1 || ovr_cnt != o0) begin
            n_bad++;
            $display("FAIL framing_pulses: ferr %0d ovr %0d, need 1 0", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_glitch();
        int f0 = ferr_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b1;
        rx = 1'b0;
        step(6);
        rx = 1'b1;
        step(64);
        n_cmp++;
        if (got_q.size() != got_rd || fifo_count !== 3'd0 || ferr_cnt != f0) begin
            n_bad++;
            $display("FAIL glitch_start: bytes %0d count %0d ferr %0d, need 0 0 0", got_q.size() - got_rd, fifo_count, ferr_cnt - f0);
        end
        exp_q.push_back(8'hFF);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                step(146);
                rx = 1'b0;
                step(1);
                rx = 1'b1;
            end
        join
        wait_got(exp_q.size());
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL glitch_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL glitch_spike: got %02h, need %02h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, g;
        logic [7:0] pat[3] = '{8'h81, 8'h7E, 8'h00};
        rx_ready = 1'b1;
        foreach (pat[i]) begin
            exp_q.push_back(pat[i]);
            send_frame(pat[i], 1'b1);
        end
        wait_got(exp_q.size());
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL b2b_data: got %02h, need %02h", g, e); end
        end
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        step(20);
        n_cmp++;
        if (fifo_count !== 3'd4 || rx_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_full: count=%0d valid=%b, need 4 1", fifo_count, rx_valid);
        end
        n_cmp++;
        if (ovr_cnt - o0 != 1) begin n_bad++; $display("FAIL overrun_pulse: got %0d pulse cycles, need 1", ovr_cnt - o0); end
        rx_ready = 1'b1;
        wait_got(exp_q.size());
        rx_ready = 1'b0;
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL overrun_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL overrun_order: got %02h, need %02h", g, e); end
        end
    endtask

    task automatic test_full_pop();
        int o0 = ovr_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            send_frame(8'h21 + 8'(i), 1'b1);
        end
        step(40);
        n_cmp++;
        if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fullpop_fill: count=%0d, need 4", fifo_count); end
        exp_q.push_back(8'h25);
        fork
            send_frame(8'h25, 1'b1);
            begin
                step(322);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        step(10);
        n_cmp++;
        if (fifo_count !== 3'd4 || ovr_cnt != o0) begin
            n_bad++;
            $display("FAIL fullpop_state: count=%0d ovr=%0d, need 4 0", fifo_count, ovr_cnt - o0);
        end
        rx_ready = 1'b1;
        wait_got(exp_q.size());
        rx_ready = 1'b0;
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL fullpop_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL fullpop_order: got %02h, need %02h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int f0 = ferr_cnt, o0 = ovr_cnt;
        logic [7:0] e, g;
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        step(10);
        n_cmp++;
        if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL rstmid_preload: count=%0d, need 1", fifo_count); end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                step(32 * 5 + 16);
                rst = 1'b1;
                #1;
                n_cmp++;
                if (rx_valid !== 1'b0 || fifo_count !== 3'd0 || rx_data !== 8'h00) begin
                    n_bad++;
                    $display("FAIL rstmid_outputs: valid=%b count=%0d data=%02h, need 0 0 00", rx_valid, fifo_count, rx_data);
                end
            end
        join
        rst = 1'b0;
        step(40);
        n_cmp++;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0 || ferr_cnt != f0 || ovr_cnt != o0) begin
            n_bad++;
            $display("FAIL rstmid_after: valid=%b count=%0d ferr=%0d ovr=%0d, need 0 0 0 0", rx_valid, fifo_count, ferr_cnt - f0, ovr_cnt - o0);
        end
        exp_q.delete();
        exp_q.push_back(8'hC3);
        rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1);
        wait_got(exp_q.size());
        n_cmp++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d bytes, need %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL rstmid_next: got %02h, need %02h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
